// File: rtl/seg_scan.sv
// Four-digit common-anode seven-segment scan driver: frame-synchronous input
// snapshot, per-slot anode guard interval and frame-counted blink blanking.
module seg_scan #(
  parameter int SCAN_DIV     = 25000,
  parameter int GUARD        = 64,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] disp,
  input  logic [3:0]  dp,
  input  logic [3:0]  blink,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [3:0]  an
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
  localparam logic [BW-1:0] BCNT_LAST = BW'(BLINK_FRAMES - 1);

  // Character code to active-low {g,f,e,d,c,b,a}; code 31 is blank.
  function automatic logic [6:0] decode(input logic [4:0] code);
    logic [6:0] s;
    case (code)
      5'd0:    s = 7'h40;
      5'd1:    s = 7'h79;
      5'd2:    s = 7'h24;
      5'd3:    s = 7'h30;
      5'd4:    s = 7'h19;
      5'd5:    s = 7'h12;
      5'd6:    s = 7'h02;
      5'd7:    s = 7'h78;
      5'd8:    s = 7'h00;
      5'd9:    s = 7'h10;
      5'd10:   s = 7'h08;
      5'd11:   s = 7'h03;
      5'd12:   s = 7'h46;
      5'd13:   s = 7'h21;
      5'd14:   s = 7'h06;
      5'd15:   s = 7'h0E;
      5'd16:   s = 7'h09;
      5'd17:   s = 7'h47;
      5'd18:   s = 7'h0C;
      5'd19:   s = 7'h23;
      5'd20:   s = 7'h2B;
      5'd21:   s = 7'h63;
      5'd22:   s = 7'h07;
      5'd23:   s = 7'h11;
      5'd24:   s = 7'h3F;
      5'd25:   s = 7'h2F;
      5'd26:   s = 7'h77;
      5'd27:   s = 7'h61;
      5'd28:   s = 7'h42;
      5'd29:   s = 7'h41;
      5'd30:   s = 7'h37;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [BW-1:0] r_bcnt;
  logic          r_phase;
  logic [19:0]   r_disp;
  logic [3:0]    r_dp;
  logic [3:0]    r_blink;
  logic [6:0]    r_seg_p1;
  logic          r_dpn_p1;
  logic [3:0]    r_an_p1;

  logic          w_cnt_wrap;
  logic          w_frame_start;
  logic          w_frame_end;
  logic [4:0]    w_code;
  logic          w_dark;
  logic [6:0]    w_seg;
  logic          w_dpn;
  logic [3:0]    w_an;

  assign w_cnt_wrap    = (r_cnt == CNT_LAST);
  assign w_frame_start = (r_cnt == '0) && (r_idx == 2'd0);
  assign w_frame_end   = w_cnt_wrap && (r_idx == 2'd3);

  always_comb begin
    w_code = r_disp[4:0];
    case (r_idx)
      2'd1:    w_code = r_disp[9:5];
      2'd2:    w_code = r_disp[14:10];
      2'd3:    w_code = r_disp[19:15];
      default: w_code = r_disp[4:0];
    endcase
  end

  // Guard keeps all anodes off at the start of each slot; blink blanking also kills dp.
  assign w_dark = (r_cnt < CNT_GUARD) || (r_phase && r_blink[r_idx]);
  assign w_an   = w_dark ? 4'hF : ~(4'b0001 << r_idx);
  assign w_seg  = w_dark ? 7'h7F : decode(w_code);
  assign w_dpn  = w_dark ? 1'b1 : ~r_dp[r_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_idx    <= 2'd0;
      r_bcnt   <= '0;
      r_phase  <= 1'b0;
      r_disp   <= {4{5'd31}};
      r_dp     <= 4'h0;
      r_blink  <= 4'h0;
      r_seg_p1 <= 7'h7F;
      r_dpn_p1 <= 1'b1;
      r_an_p1  <= 4'hF;
    end else begin
      if (w_cnt_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end

      if (w_frame_start) begin
        r_disp  <= disp;
        r_dp    <= dp;
        r_blink <= blink;
      end

      if (w_frame_end) begin
        if (r_bcnt == BCNT_LAST) begin
          r_bcnt  <= '0;
          r_phase <= ~r_phase;
        end else begin
          r_bcnt <= r_bcnt + BW'(1);
        end
      end

      // Stage p1: registered display drive, one cycle behind the counters.
      r_seg_p1 <= w_seg;
      r_dpn_p1 <= w_dpn;
      r_an_p1  <= w_an;
    end
  end

  assign seg  = r_seg_p1;
  assign dp_n = r_dpn_p1;
  assign an   = r_an_p1;

endmodule

// File: doc/seg_scan.md
# seg_scan

Four-digit seven-segment scan driver that sits directly downstream of the top-level mode manager. It consumes the manager's 20-bit display word (four 5-bit character codes) plus per-digit decimal-point and blink masks. It snapshots them once per frame, decodes each code to segments, and time-multiplexes the board's common-anode display. Anode guard intervals suppress ghosting, and a frame-based phase blanks blinking digits (editor cursor).

## Interface
- `SCAN_DIV`, 25000: clock cycles per digit slot (100 MHz gives a 1 kHz digit rate); must be ≥ `GUARD`+2.
- `GUARD`, 64: cycles at the start of each slot with all anodes off; must be ≥ 1.
- `BLINK_FRAMES`, 125: frames per blink half-period.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `disp`  in  20  character codes; `[19:15]` is the leftmost digit (digit 3), `[4:0]` is the rightmost (digit 0).
- `dp`  in  4  decimal point enable per digit, bit k drives digit k; active-high.
- `blink`  in  4  blink enable per digit; active-high.
- `seg`  out  7  segments `{g,f,e,d,c,b,a}`, active-low, registered.
- `dp_n`  out  1  decimal point, active-low, registered.
- `an`  out  4  anode enables, `an[k]` drives digit k, active-low, registered.

## Operation
- Slot counter `cnt` runs 0..`SCAN_DIV`-1.
  - When it wraps, digit index `idx` increments mod 4 (order 0,1,2,3,0).
  - A frame is the 4 slots of `idx` 0..3.
- Frame snapshot: on every cycle with `cnt`==0 and `idx`==0, register `disp`, `dp` and `blink`.
  - Outputs use only the snapshot, so input changes mid-frame never tear a frame.
- Blink phase:
  - `bcnt` counts completed frames; it increments on the cycle with `cnt`==`SCAN_DIV`-1 and `idx`==3.
  - When `bcnt` reaches `BLINK_FRAMES`-1 it clears to 0 and `phase` toggles.
- Output register, updated every cycle from the current `cnt`/`idx`/snapshot/`phase`:
  - Guard condition (`cnt` < `GUARD`), or blank condition (`phase`==1 and snapshot blink[`idx`]==1): `an`=4'b1111, `seg`=7'h7F, `dp_n`=1.
  - Otherwise: `an` has only bit `idx` low; `seg`=decode(snapshot code[`idx`]); `dp_n`=~snapshot dp[`idx`].
- Decode table, code -> `seg` hex (active-low `{g..a}`):
  - Digits 0-9: 40,79,24,30,19,12,02,78,00,10.
  - 10 A=08, 11 b=03, 12 C=46, 13 d=21, 14 E=06, 15 F=0E.
  - 16 H=09, 17 L=47, 18 P=0C, 19 o=23, 20 n=2B, 21 u=63, 22 t=07, 23 y=11, 24 -=3F, 25 r=2F, 26 _=77, 27 J=61, 28 G=42, 29 U=41, 30 ==37.
  - 31 = blank (7F).
- No inputs other than `rst` affect `cnt`, `idx`, `bcnt` or `phase`.

## Timing
- Reset, on the first edge with `rst`=1:
  - `an`=4'b1111, `seg`=7'h7F, `dp_n`=1.
  - `cnt`=0, `idx`=0, `bcnt`=0, `phase`=0.
  - Snapshot = all codes 31, dp=0, blink=0.
- Reset asserted mid-frame: state is discarded and outputs go dark on that edge. The scan restarts at digit 0 on the first edge after deassertion, and that cycle also loads the snapshot.
- Output latency: outputs at edge t+1 reflect the counters at edge t, so exactly 1 cycle.
- Per slot:
  - `GUARD` cycles dark, then `SCAN_DIV`-`GUARD` cycles with the digit lit.
  - Anodes never overlap: at least `GUARD` dark cycles between any two lit digits.
- Frame period = 4·`SCAN_DIV` cycles. Blink full period = 2·`BLINK_FRAMES` frames.
- Input change latency: visible from the next frame start, at most 4·`SCAN_DIV`+1 cycles after the change.
- Simultaneous snapshot and `bcnt` wrap: these cannot coincide, since they occur on different counter states. `phase` changes take effect in the first slot of the next frame.
- Blink with `phase`==1 overrides `dp`: a blanked digit also turns its dp off.

## Test plan
Use `SCAN_DIV`=8, `GUARD`=2, `BLINK_FRAMES`=2 for all scenarios.
- Reset with `disp`={5'd16,5'd14,5'd17,5'd17}, then release -> frame 0 shows the digits in order 0..3; digit 0 lit outputs `seg`=0x47, digit 3 lit outputs `seg`=0x09; `an` steps 1110,1101,1011,0111; each slot is 2 dark cycles then 6 lit cycles.
- Load `disp`={31,14,25,25} (error word) mid-frame -> the current frame is unchanged; from the next frame digit 3 is dark, digit 2 shows 0x06, and digits 1 and 0 show 0x2F.
- `dp`=4'b0010 -> `dp_n`=0 only during digit 1's lit cycles; 1 at all other times, including guards.
- `blink`=4'b0001 -> digit 0 is lit in frames 0-1, dark in frames 2-3, lit again in frames 4-5; the other digits are lit every frame.
- Assert `rst` for 1 cycle during digit 2's lit window -> outputs dark on that edge, `an`=1111 for the next 2 cycles, then digit 0 is lit.
- Sweep codes 0-31 through digit 0 -> `seg` matches the decode table exactly for every code.
